// File: rtl/sp_ram_fifo_pkg.sv
// Shared defaults and grant encoding for the single-port-RAM FIFO.
package sp_ram_fifo_pkg;

  localparam int unsigned DEPTH_DEF = 32;
  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned AW_DEF    = 5;
  localparam int unsigned CNT_W     = 6;

  typedef enum logic {
    GRANT_WRITE = 1'b0,
    GRANT_READ  = 1'b1
  } grant_e;

endpackage

// File: rtl/sp_ram_fifo_if.sv
// Producer/consumer handshakes plus the RAM master bus of the FIFO.
interface sp_ram_fifo_if
  import sp_ram_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned AW    = AW_DEF
);

  logic             enq_valid;
  logic             enq_ready;
  logic [WIDTH-1:0] enq_bits;
  logic             deq_valid;
  logic             deq_ready;
  logic [WIDTH-1:0] deq_bits;
  logic [AW-1:0]    ram_addr;
  logic             ram_en;
  logic             ram_wmode;
  logic [WIDTH-1:0] ram_wmask;
  logic [WIDTH-1:0] ram_wdata;
  logic [WIDTH-1:0] ram_rdata;

  modport master (
    output enq_valid, enq_bits, deq_ready, ram_rdata,
    input  enq_ready, deq_valid, deq_bits,
    input  ram_addr, ram_en, ram_wmode, ram_wmask, ram_wdata
  );

  modport slave (
    input  enq_valid, enq_bits, deq_ready, ram_rdata,
    output enq_ready, deq_valid, deq_bits,
    output ram_addr, ram_en, ram_wmode, ram_wmask, ram_wdata
  );

endinterface

// File: rtl/sp_ram_fifo_obuf.sv
// Two-entry output queue: captures RAM read data, presents it as a valid/ready source.
module sp_ram_fifo_obuf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_clear,
  input  logic             i_cap_valid,
  input  logic [WIDTH-1:0] i_cap_data,
  input  logic             i_deq_ready,
  output logic             o_deq_valid,
  output logic [WIDTH-1:0] o_deq_bits,
  output logic [1:0]       o_cnt
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_head;
  logic [1:0]       r_cnt;

  logic w_pop;
  logic w_push;
  logic w_tail;

  always_comb begin
    w_pop  = i_deq_ready && (r_cnt != 2'd0);
    // A full buffer only accepts a capture when a pop frees a slot the same cycle
    w_push = i_cap_valid && ((r_cnt != 2'd2) || w_pop);
    w_tail = r_head ^ r_cnt[0];
  end

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_head <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      if (w_pop) begin
        r_head <= ~r_head;
      end
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_clear && w_push) begin
      r_mem[w_tail] <= i_cap_data;
    end
  end

  always_comb begin
    o_deq_valid = (r_cnt != 2'd0);
    o_deq_bits  = (r_cnt != 2'd0) ? r_mem[r_head] : '0;
    o_cnt       = r_cnt;
  end

endmodule

// File: rtl/sp_ram_fifo.sv
// FIFO backed by an external single-port masked RAM; round-robin write/read arbitration.
module sp_ram_fifo
  import sp_ram_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned AW    = AW_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  sp_ram_fifo_if.slave     bus
);

  localparam logic [AW:0] RamFull = (AW + 1)'(DEPTH);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_ram_cnt;
  logic          r_inflight;
  grant_e        r_last_grant;

  logic             w_live;
  logic             w_full;
  logic             w_wr_req;
  logic             w_rd_req;
  logic             w_read_wins;
  logic             w_contest;
  logic             w_grant_wr;
  logic             w_grant_rd;
  logic [1:0]       w_obuf_cnt;
  logic             w_deq_valid;
  logic [WIDTH-1:0] w_deq_bits;

  always_comb begin
    w_live      = !reset && !flush;
    w_full      = (r_ram_cnt == RamFull);
    w_wr_req    = bus.enq_valid && !w_full;
    // Keep obuf plus any returning read within two slots so a capture always fits
    w_rd_req    = (r_ram_cnt != '0) && ((w_obuf_cnt + {1'b0, r_inflight}) < 2'd2);
    w_read_wins = (r_last_grant == GRANT_WRITE);
    w_contest   = w_wr_req && w_rd_req;
    w_grant_wr  = w_live && w_wr_req && !(w_rd_req && w_read_wins);
    w_grant_rd  = w_live && w_rd_req && !(w_wr_req && !w_read_wins);
  end

  always_comb begin
    bus.enq_ready = !w_full && !(w_rd_req && w_read_wins);
    bus.ram_en    = w_grant_wr || w_grant_rd;
    bus.ram_wmode = w_grant_wr;
    bus.ram_addr  = '0;
    if (w_grant_wr) begin
      bus.ram_addr = r_wptr;
    end else if (w_grant_rd) begin
      bus.ram_addr = r_rptr;
    end
    bus.ram_wmask = w_grant_wr ? '1 : '0;
    bus.ram_wdata = w_grant_wr ? bus.enq_bits : '0;
    bus.deq_valid = w_deq_valid;
    bus.deq_bits  = w_deq_bits;
    count         = CNT_W'(r_ram_cnt) + CNT_W'(r_inflight) + CNT_W'(w_obuf_cnt);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_ram_cnt    <= '0;
      r_inflight   <= 1'b0;
      r_last_grant <= GRANT_WRITE;
    end else if (flush) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_ram_cnt  <= '0;
      r_inflight <= 1'b0;
    end else begin
      if (w_grant_wr) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_grant_rd) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_ram_cnt  <= r_ram_cnt + (AW + 1)'(w_grant_wr) - (AW + 1)'(w_grant_rd);
      r_inflight <= w_grant_rd;
      if (w_contest) begin
        r_last_grant <= w_grant_wr ? GRANT_WRITE : GRANT_READ;
      end
    end
  end

  // Clearing on flush/reset also drops read data returning in the following cycle
  sp_ram_fifo_obuf #(
    .WIDTH(WIDTH)
  ) u_obuf (
    .i_clk       (clock),
    .i_clear     (reset || flush),
    .i_cap_valid (r_inflight),
    .i_cap_data  (bus.ram_rdata),
    .i_deq_ready (bus.deq_ready),
    .o_deq_valid (w_deq_valid),
    .o_deq_bits  (w_deq_bits),
    .o_cnt       (w_obuf_cnt)
  );

endmodule

// File: tb/tb_sp_ram_fifo.sv
// Self-checking bench: per-cycle vector table, scoreboard on deq, RAM behavioural model.
module tb_sp_ram_fifo;

  logic       clock = 1'b0;
  logic       reset;
  logic       flush;
  logic [5:0] count;

  int n_checks = 0;
  int n_err    = 0;
  int n_acc    = 0;
  int n_pop    = 0;

  logic [7:0] sb [$];
  logic [7:0] mem [32];

  sp_ram_fifo_if #(.WIDTH(8), .AW(5)) bus ();

  sp_ram_fifo #(
    .DEPTH(32),
    .WIDTH(8),
    .AW   (5)
  ) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .count (count),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // RAM model: read data valid for exactly one cycle, junk otherwise
  always @(posedge clock) begin
    if (bus.ram_en && bus.ram_wmode) begin
      mem[bus.ram_addr] <= (mem[bus.ram_addr] & ~bus.ram_wmask) | (bus.ram_wdata & bus.ram_wmask);
    end
    if (bus.ram_en && !bus.ram_wmode) begin
      bus.ram_rdata <= mem[bus.ram_addr];
    end else begin
      bus.ram_rdata <= 8'($urandom);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clock) begin
    if (reset || flush) begin
      sb.delete();
    end else begin
      if (bus.ram_en && bus.ram_wmode) begin
        check("wr_mask", 32'(bus.ram_wmask), 32'hff);
        check("wr_data", 32'(bus.ram_wdata), 32'(bus.enq_bits));
      end
      if (bus.deq_valid && bus.deq_ready) begin
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) check("deq_data", 32'(bus.deq_bits), 32'(sb.pop_front()));
        n_pop++;
      end
      if (bus.enq_valid && bus.enq_ready) begin
        sb.push_back(bus.enq_bits);
        n_acc++;
      end
    end
  end

  typedef struct {
    logic       ev;
    logic [7:0] eb;
    logic       dr;
    logic       er;
    logic       dv;
    logic [7:0] db;
    logic [5:0] cnt;
    logic       ren;
    logic       rwm;
    logic [4:0] radr;
  } vec_t;

  vec_t vecs [20];

  task automatic do_reset();
    reset = 1'b1;
    flush = 1'b0;
    bus.enq_valid = 1'b0;
    bus.enq_bits  = 8'h00;
    bus.deq_ready = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    n_acc = 0;
    n_pop = 0;
  endtask

  task automatic push(input logic [7:0] d);
    logic ok;
    int   n;
    ok = 1'b0;
    n  = 0;
    bus.enq_valid = 1'b1;
    bus.enq_bits  = d;
    do begin
      @(negedge clock);
      ok = bus.enq_ready;
      @(posedge clock);
      #1;
      n++;
    end while (!ok && n < 100);
    bus.enq_valid = 1'b0;
    check("enq_accept", 32'(ok), 32'd1);
  endtask

  task automatic pop_one_then_wait_read(input string name);
    logic found;
    bus.deq_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.deq_ready = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (bus.ram_en && !bus.ram_wmode) begin
        found = 1'b1;
        break;
      end
    end
    check({name, "_read_issue"}, 32'(found), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         alt_bad;
    int         wraps_w;
    int         wraps_r;
    int         sent;
    int         stale;
    logic       prev_wm;
    logic       acc;
    logic [4:0] pw;
    logic [4:0] pr;
    logic       found;

    //            ev  eb     dr   er  dv  db     cnt  ren rwm adr
    vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 6'd0, 1'b0, 1'b0, 5'd0};
    vecs[1]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, 6'd0, 1'b1, 1'b1, 5'd0};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 6'd1, 1'b1, 1'b0, 5'd0};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 6'd1, 1'b0, 1'b0, 5'd0};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 6'd1, 1'b0, 1'b0, 5'd0};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 6'd1, 1'b0, 1'b0, 5'd0};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 6'd0, 1'b0, 1'b0, 5'd0};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 6'd0, 1'b0, 1'b0, 5'd0};
    vecs[8]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 6'd0, 1'b1, 1'b1, 5'd1};
    vecs[9]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 8'h00, 6'd1, 1'b1, 1'b0, 5'd1};
    vecs[10] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h00, 6'd1, 1'b1, 1'b1, 5'd2};
    vecs[11] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h11, 6'd2, 1'b1, 1'b1, 5'd3};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 6'd3, 1'b1, 1'b0, 5'd2};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h11, 6'd3, 1'b0, 1'b0, 5'd0};
    vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h11, 6'd3, 1'b0, 1'b0, 5'd0};
    vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11, 6'd3, 1'b0, 1'b0, 5'd0};
    vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22, 6'd2, 1'b1, 1'b0, 5'd3};
    vecs[17] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 6'd1, 1'b0, 1'b0, 5'd0};
    vecs[18] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 6'd1, 1'b0, 1'b0, 5'd0};
    vecs[19] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 6'd0, 1'b0, 1'b0, 5'd0};

    reset = 1'b1;
    flush = 1'b0;
    bus.enq_valid = 1'b0;
    bus.enq_bits  = 8'h00;
    bus.deq_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    // Cycle-exact vectors: first-beat latency and round-robin contention
    for (int i = 0; i < 20; i++) begin
      bus.enq_valid = vecs[i].ev;
      bus.enq_bits  = vecs[i].eb;
      bus.deq_ready = vecs[i].dr;
      @(negedge clock);
      check($sformatf("v%0d_enq_ready", i), 32'(bus.enq_ready), 32'(vecs[i].er));
      check($sformatf("v%0d_deq_valid", i), 32'(bus.deq_valid), 32'(vecs[i].dv));
      check($sformatf("v%0d_deq_bits", i), 32'(bus.deq_bits), 32'(vecs[i].db));
      check($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].cnt));
      check($sformatf("v%0d_ram_en", i), 32'(bus.ram_en), 32'(vecs[i].ren));
      check($sformatf("v%0d_ram_wmode", i), 32'(bus.ram_wmode), 32'(vecs[i].rwm));
      check($sformatf("v%0d_ram_addr", i), 32'(bus.ram_addr), 32'(vecs[i].radr));
      @(posedge clock);
      #1;
    end

    // Fill to DEPTH+2, refuse a 35th beat, then drain in order
    do_reset();
    for (int i = 0; i < 34; i++) push(8'(i));
    repeat (2) @(negedge clock);
    check("full_count", 32'(count), 32'd34);
    check("full_enq_ready", 32'(bus.enq_ready), 32'd0);
    @(posedge clock);
    #1;
    bus.enq_valid = 1'b1;
    bus.enq_bits  = 8'hEE;
    repeat (5) @(posedge clock);
    #1;
    bus.enq_valid = 1'b0;
    check("no_35th_beat", 32'(n_acc), 32'd34);
    check("full_count_hold", 32'(count), 32'd34);
    bus.deq_ready = 1'b1;
    for (int c = 0; c < 300 && n_pop < 34; c++) begin
      @(posedge clock);
      #1;
    end
    check("drain_pops", 32'(n_pop), 32'd34);
    check("drain_count", 32'(count), 32'd0);

    // Sustained streaming: strict write/read alternation once settled
    do_reset();
    alt_bad = 0;
    prev_wm = 1'b0;
    bus.enq_valid = 1'b1;
    bus.enq_bits  = 8'h00;
    bus.deq_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (c >= 10 && (!bus.ram_en || bus.ram_wmode == prev_wm)) alt_bad++;
      prev_wm = bus.ram_wmode;
      acc = bus.enq_ready;
      @(posedge clock);
      #1;
      if (acc) bus.enq_bits = bus.enq_bits + 8'd1;
    end
    bus.enq_valid = 1'b0;
    check("stream_alternation_errors", 32'(alt_bad), 32'd0);
    check("stream_beats_ge_95", 32'(n_pop >= 95), 32'd1);
    repeat (12) @(posedge clock);
    #1;
    check("stream_drained", 32'(count), 32'd0);

    // Pointer wrap with random back-pressure
    do_reset();
    wraps_w = 0;
    wraps_r = 0;
    sent = 0;
    pw = 5'd0;
    pr = 5'd0;
    bus.enq_valid = 1'b1;
    bus.enq_bits  = 8'($urandom);
    for (int c = 0; c < 3000 && n_pop < 100; c++) begin
      @(negedge clock);
      if (bus.ram_en && bus.ram_wmode) begin
        if (bus.ram_addr == 5'd0 && pw == 5'd31) wraps_w++;
        pw = bus.ram_addr;
      end else if (bus.ram_en) begin
        if (bus.ram_addr == 5'd0 && pr == 5'd31) wraps_r++;
        pr = bus.ram_addr;
      end
      acc = bus.enq_valid && bus.enq_ready;
      @(posedge clock);
      #1;
      if (acc) begin
        sent++;
        bus.enq_bits = 8'($urandom);
        if (sent == 100) bus.enq_valid = 1'b0;
      end
      bus.deq_ready = 1'($urandom_range(0, 1));
    end
    bus.deq_ready = 1'b0;
    check("wrap_pops", 32'(n_pop), 32'd100);
    check("wrap_wptr_ge3", 32'(wraps_w >= 3), 32'd1);
    check("wrap_rptr_ge3", 32'(wraps_r >= 3), 32'd1);

    // Flush the cycle after a read issue with five beats held
    do_reset();
    for (int i = 0; i < 6; i++) push(8'h50 + 8'(i));
    repeat (4) @(posedge clock);
    #1;
    pop_one_then_wait_read("flush");
    check("flush_pre_count", 32'(count), 32'd5);
    @(posedge clock);
    #1;
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    @(negedge clock);
    check("flush_count", 32'(count), 32'd0);
    check("flush_deq_valid", 32'(bus.deq_valid), 32'd0);
    repeat (2) @(negedge clock);
    check("flush_dropped_read", 32'(bus.deq_valid), 32'd0);
    @(posedge clock);
    #1;
    push(8'h3C);
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (bus.deq_valid) begin
        found = 1'b1;
        break;
      end
    end
    check("post_flush_deq_valid", 32'(found), 32'd1);
    check("post_flush_deq_bits", 32'(bus.deq_bits), 32'h3C);
    @(posedge clock);
    #1;
    bus.deq_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.deq_ready = 1'b0;

    // Reset mid-stream with seven beats held and a read in flight
    do_reset();
    for (int i = 0; i < 8; i++) push(8'h70 + 8'(i));
    repeat (4) @(posedge clock);
    #1;
    pop_one_then_wait_read("rst");
    check("rst_pre_count", 32'(count), 32'd7);
    @(posedge clock);
    #1;
    reset = 1'b1;
    bus.enq_valid = 1'b1;
    bus.enq_bits  = 8'h99;
    @(posedge clock);
    #1;
    reset = 1'b0;
    bus.enq_valid = 1'b0;
    @(negedge clock);
    check("rst_enq_ready", 32'(bus.enq_ready), 32'd1);
    check("rst_deq_valid", 32'(bus.deq_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ram_en", 32'(bus.ram_en), 32'd0);
    check("rst_ram_wmode", 32'(bus.ram_wmode), 32'd0);
    check("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
    check("rst_ram_wmask", 32'(bus.ram_wmask), 32'd0);
    check("rst_ram_wdata", 32'(bus.ram_wdata), 32'd0);
    check("rst_deq_bits", 32'(bus.deq_bits), 32'd0);
    @(posedge clock);
    #1;
    bus.deq_ready = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clock);
      if (bus.deq_valid) stale++;
    end
    check("rst_no_stale_beat", 32'(stale), 32'd0);
    @(posedge clock);
    #1;
    bus.deq_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
